// File: rtl/tate_result_reader.sv
// Host-side reader for the Tate pairing core's windowed result port: walks the one-hot
// window select, captures each chunk and streams it out as words over valid/ready.
module tate_result_reader #(
    parameter int CHUNK_W = 150,
    parameter int NCHUNK  = 8,
    parameter int WORD_W  = 30
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               pair_done,
    output logic [NCHUNK-1:0]  sel,
    input  logic [CHUNK_W-1:0] pair_out,
    output logic [WORD_W-1:0]  word_data,
    output logic               word_valid,
    input  logic               word_ready,
    output logic               word_last,
    output logic               busy
);
    // state | meaning
    // WAIT  | idle, waiting for the core's done level
    // LOAD  | sel driven for one cycle, window captured at the edge
    // SEND  | shifting the captured window out word by word
    // FIN   | all windows delivered, parked until start or reset
    localparam int WPC   = CHUNK_W / WORD_W;
    localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int CNT_W = $clog2(WPC + 1);

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CHUNK_W-1:0] shreg_q, shreg_d;
    logic [NCHUNK-1:0]  sel_q, sel_d;

    logic               last_idx;
    logic               last_cnt;
    logic [IDX_W-1:0]   idx_inc;

    assign last_idx = (idx_q == IDX_W'(NCHUNK - 1));
    assign last_cnt = (cnt_q == CNT_W'(WPC - 1));
    assign idx_inc  = idx_q + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAIT;
            idx_q   <= '0;
            cnt_q   <= '0;
            shreg_q <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            sel_q   <= sel_d;
        end
    end

    // sel_d defaults to zero so the select is only ever asserted for the LOAD cycle
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        sel_d   = '0;
        if (start) begin
            state_d = WAIT;
            idx_d   = '0;
            cnt_d   = '0;
            shreg_d = '0;
        end else begin
            case (state_q)
                WAIT: begin
                    if (pair_done) begin
                        state_d = LOAD;
                        sel_d   = NCHUNK'(1) << idx_q;
                    end
                end
                LOAD: begin
                    shreg_d = pair_out;
                    cnt_d   = '0;
                    state_d = SEND;
                end
                SEND: begin
                    if (word_ready) begin
                        shreg_d = shreg_q >> WORD_W;
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (last_cnt) begin
                            if (last_idx) begin
                                state_d = FIN;
                            end else begin
                                idx_d   = idx_inc;
                                state_d = LOAD;
                                sel_d   = NCHUNK'(1) << idx_inc;
                            end
                        end
                    end
                end
                default: state_d = FIN;
            endcase
        end
    end

    always_comb begin
        sel        = sel_q;
        word_valid = (state_q == SEND);
        word_data  = shreg_q[WORD_W-1:0];
        word_last  = (state_q == SEND) && last_idx && last_cnt;
        busy       = (state_q == LOAD) || (state_q == SEND);
    end
endmodule

// File: tb/tb_tate_result_reader.sv
// Bench for tate_result_reader: behavioural pairing-core window model plus word/sel scoreboards.
module tb_tate_result_reader;
    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         pair_done;
    logic [7:0]   sel;
    logic [149:0] pair_out;
    logic [29:0]  word_data;
    logic         word_valid;
    logic         word_ready;
    logic         word_last;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;
    logic ones_mode = 1'b0;

    logic [30:0] exp_q[$];
    logic [7:0]  exp_sel_q[$];
    logic [7:0]  prev_sel = '0;

    always #5 clk = ~clk;

    tate_result_reader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pair_done  (pair_done),
        .sel        (sel),
        .pair_out   (pair_out),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_last  (word_last),
        .busy       (busy)
    );

    // Core model: window k holds words 5k..5k+4, LSB word first; garbage unless sel is one-hot.
    always_comb begin
        pair_out = {150{1'b1}};
        for (int k = 0; k < 8; k++) begin
            if (sel == (8'h01 << k)) begin
                for (int j = 0; j < 5; j++) pair_out[j*30 +: 30] = 30'(k*5 + j);
                if (ones_mode && k == 7) pair_out = {36'd0, {114{1'b1}}};
            end
        end
    end

    function automatic logic [29:0] exp_word(input int n);
        if (ones_mode && n >= 35) begin
            if (n <= 37)      return 30'h3FFFFFFF;
            else if (n == 38) return 30'h00FFFFFF;
            else              return 30'h00000000;
        end
        return 30'(n);
    endfunction

    task automatic load_scoreboard();
        exp_q.delete();
        exp_sel_q.delete();
        pops = 0;
        for (int n = 0; n < 40; n++) exp_q.push_back({(n == 39), exp_word(n)});
        for (int k = 0; k < 8; k++) exp_sel_q.push_back(8'h01 << k);
    endtask

    always @(negedge clk) begin
        if (!reset && !start && word_valid && word_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL extra_word: got data=%h last=%b, none expected", word_data, word_last);
            end else begin
                logic [30:0] e;
                e = exp_q.pop_front();
                if ({word_last, word_data} !== e) begin
                    failures++;
                    $display("FAIL word%0d: got data=%h last=%b, want data=%h last=%b",
                             pops, word_data, word_last, e[29:0], e[30]);
                end
                pops++;
            end
        end
        if (sel !== 8'h00 && sel !== prev_sel) begin
            checks++;
            if (exp_sel_q.size() == 0) begin
                failures++;
                $display("FAIL sel_extra: got sel=%h, none expected", sel);
            end else begin
                logic [7:0] es;
                es = exp_sel_q.pop_front();
                if (sel !== es) begin
                    failures++;
                    $display("FAIL sel_seq: got sel=%h, want %h", sel, es);
                end
            end
        end
        prev_sel = sel;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pops(input int target, input string name);
        for (int i = 0; i < 400 && pops < target; i++) step();
        checks++;
        if (pops < target) begin
            failures++;
            $display("FAIL %s_timeout: got %0d words, want %0d", name, pops, target);
        end
    endtask

    task automatic wait_word(input int n, input string name);
        for (int i = 0; i < 400 && !(pops == n && word_valid); i++) step();
        checks++;
        if (!(pops == n && word_valid)) begin
            failures++;
            $display("FAIL %s_reach: got pops=%0d valid=%b, want pops=%0d valid=1", name, pops, word_valid, n);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0 || exp_sel_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: got %0d words %0d sels left, want 0 0", name, exp_q.size(), exp_sel_q.size());
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (sel !== 8'h00 || word_valid !== 1'b0 || word_last !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s: got sel=%h valid=%b last=%b busy=%b, want 00 0 0 0",
                     name, sel, word_valid, word_last, busy);
        end
    endtask

    task automatic restart();
        start = 1'b1;
        load_scoreboard();
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; pair_done = 1'b0; word_ready = 1'b1;
        step(); step();
        reset = 1'b0;
        checks++;
        if (sel !== 8'h00 || word_valid !== 1'b0 || word_last !== 1'b0 || word_data !== 30'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_vals: got sel=%h valid=%b last=%b data=%h busy=%b, want all 0",
                     sel, word_valid, word_last, word_data, busy);
        end
    endtask

    task automatic test_first_word();
        load_scoreboard();
        step(); step();
        check_idle("wait_idle");
        pair_done = 1'b1;
        step();
        checks++;
        if (sel !== 8'h01 || word_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL load_cycle: got sel=%h valid=%b busy=%b, want 01 0 1", sel, word_valid, busy);
        end
        step();
        checks++;
        if (word_valid !== 1'b1 || word_data !== 30'd0 || sel !== 8'h00) begin
            failures++;
            $display("FAIL first_word: got valid=%b data=%h sel=%h, want 1 0 00", word_valid, word_data, sel);
        end
    endtask

    task automatic test_full_stream();
        wait_pops(40, "full");
        check_drained("full");
        for (int i = 0; i < 6; i++) begin
            step();
            check_idle("fin_idle");
        end
    endtask

    task automatic test_stall();
        restart();
        wait_word(12, "stall");
        word_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (word_valid !== 1'b1 || {word_last, word_data} !== exp_q[0]) begin
                failures++;
                $display("FAIL stall_hold: got valid=%b data=%h last=%b, want 1 %h %b",
                         word_valid, word_data, word_last, exp_q[0][29:0], exp_q[0][30]);
            end
        end
        word_ready = 1'b1;
        wait_pops(40, "stall");
        check_drained("stall");
        step();
        check_idle("stall_fin");
    endtask

    task automatic test_window7_pad();
        ones_mode = 1'b1;
        restart();
        wait_pops(40, "win7");
        check_drained("win7");
        step();
        ones_mode = 1'b0;
    endtask

    task automatic test_start_abort();
        restart();
        wait_word(12, "abort");
        start = 1'b1;
        load_scoreboard();
        step();
        start = 1'b0;
        check_idle("abort_wait");
        step();
        checks++;
        if (sel !== 8'h01 || busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_reload: got sel=%h busy=%b, want 01 1", sel, busy);
        end
        wait_pops(40, "abort");
        check_drained("abort");
    endtask

    task automatic test_reset_mid();
        restart();
        wait_word(20, "rstmid");
        reset = 1'b1;
        load_scoreboard();
        step();
        checks++;
        if (sel !== 8'h00 || word_valid !== 1'b0 || word_last !== 1'b0 || word_data !== 30'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: got sel=%h valid=%b last=%b data=%h busy=%b, want all 0",
                     sel, word_valid, word_last, word_data, busy);
        end
        reset = 1'b0;
        wait_pops(40, "rstmid");
        check_drained("rstmid");
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_full_stream();
        test_stall();
        test_window7_pad();
        test_start_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
